clock_time_setter: RTL and testbench

User time-entry front end for the 24 h HH:MM:SS clock. Conditions three raw pushbuttons and lets the user edit hours, minutes and seconds in sequence. Produces a load request (seconds-of-day value, 0..86399) that the clock core consumes through a valid/ready handshake. Exports the field being edited and the edit values so the display path can show and blink them.

---
 rtl/clock_pkg.sv | 47 ++++
 rtl/button_conditioner.sv | 77 +++++++
 rtl/clock_time_setter.sv | 173 +++++++++++++++++
 tb/tb_clock_time_setter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, constants and arithmetic helpers for the time-entry front end.
package clock_pkg;

   localparam int SEC_W = 17;
   localparam int HH_W  = 5;
   localparam int MS_W  = 6;

   localparam logic [SEC_W-1:0] SECONDS_PER_DAY  = 17'd86400;
   localparam logic [SEC_W-1:0] SECONDS_PER_HOUR = 17'd3600;
   localparam logic [SEC_W-1:0] SECONDS_PER_MIN  = 17'd60;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SET_HH = 3'd1,
      ST_SET_MM = 3'd2,
      ST_SET_SS = 3'd3,
      ST_COMMIT = 3'd4
   } state_e;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HH   = 2'd1;
   localparam logic [1:0] FIELD_MM   = 2'd2;
   localparam logic [1:0] FIELD_SS   = 2'd3;

   // One wrap-around step of an edit field; simultaneous up and down cancel.
   function automatic logic [MS_W-1:0] step_field(input logic [MS_W-1:0] v,
                                                   input logic [MS_W-1:0] max_v,
                                                   input logic up,
                                                   input logic dn);
      logic [MS_W-1:0] r;
      r = v;
      if (up && !dn) begin
         r = (v == max_v) ? '0 : v + 6'd1;
      end else if (dn && !up) begin
         r = (v == '0) ? max_v : v - 6'd1;
      end
      return r;
   endfunction

   // HH:MM:SS to seconds-of-day; at most 86399, so 17 bits never overflow.
   function automatic logic [SEC_W-1:0] to_seconds(input logic [HH_W-1:0] hh,
                                                    input logic [MS_W-1:0] mm,
                                                    input logic [MS_W-1:0] ss);
      return SEC_W'(hh) * SECONDS_PER_HOUR + SEC_W'(mm) * SECONDS_PER_MIN + SEC_W'(ss);
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton to one-cycle press pulses: 2-FF sync, debounce, rising-edge
// detect and, when REPEAT_EN is set, hold-then-repeat pulses while held.
module button_conditioner #(
   parameter longint DEBOUNCE_CYC = 4,
   parameter longint HOLD_CYC     = 10,
   parameter longint REPEAT_CYC   = 5,
   parameter bit     REPEAT_EN    = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam longint RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int     DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int     RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LOAD   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [RP_W-1:0] HOLD_LOAD = RP_W'(HOLD_CYC - 1);
   localparam logic [RP_W-1:0] REP_LOAD  = RP_W'(REPEAT_CYC - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;

   // Debounce down-counter restarts on any cycle where the input agrees with
   // the accepted level; repeat counter runs only while the level stays high.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = DB_LOAD;
      rp_cnt_d = rp_cnt_q;
      press_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == '0) begin
            level_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q - 1'b1;
         end
      end
      if (level_d && !level_q) begin
         press_d  = 1'b1;
         rp_cnt_d = HOLD_LOAD;
      end else if (level_d && level_q) begin
         if (rp_cnt_q == '0) begin
            press_d  = REPEAT_EN;
            rp_cnt_d = REP_LOAD;
         end else begin
            rp_cnt_d = rp_cnt_q - 1'b1;
         end
      end
   end

   // Synchroniser, accepted level, counters and the registered pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
         db_cnt_q <= '0;
         rp_cnt_q <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         level_q  <= level_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
         rp_cnt_q <= rp_cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/clock_time_setter.sv
// Time-entry front end: edit HH, MM, SS in turn and hand the result to the
// clock core as a seconds-of-day load over valid/ready.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | not editing; mode press snapshots cur_seconds
//   ST_SET_HH | editing hours, inc/dec wrap 0..23
//   ST_SET_MM | editing minutes, inc/dec wrap 0..59
//   ST_SET_SS | editing seconds; mode press latches load_seconds
//   ST_COMMIT | load_valid high until the core takes it; buttons ignored
module clock_time_setter
   import clock_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int HOLD_MS     = 500,
   parameter int REPEAT_MS   = 100,
   parameter int TIMEOUT_S   = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic [SEC_W-1:0] cur_seconds,
   input  logic             load_ready,
   output logic             load_valid,
   output logic [SEC_W-1:0] load_seconds,
   output logic             edit_active,
   output logic [1:0]       edit_field,
   output logic [HH_W-1:0]  edit_hh,
   output logic [MS_W-1:0]  edit_mm,
   output logic [MS_W-1:0]  edit_ss
);

   // 64-bit products: HOLD_MS * CLK_HZ overflows 32 bits at 50 MHz.
   localparam longint DB_RAW  = (longint'(DEBOUNCE_MS) * longint'(CLK_HZ)) / 1000;
   localparam longint HD_RAW  = (longint'(HOLD_MS) * longint'(CLK_HZ)) / 1000;
   localparam longint RP_RAW  = (longint'(REPEAT_MS) * longint'(CLK_HZ)) / 1000;
   localparam longint TMO_RAW = longint'(TIMEOUT_S) * longint'(CLK_HZ);
   localparam longint DB_CYC  = (DB_RAW < 1) ? 1 : DB_RAW;
   localparam longint HD_CYC  = (HD_RAW < 1) ? 1 : HD_RAW;
   localparam longint RP_CYC  = (RP_RAW < 1) ? 1 : RP_RAW;
   localparam longint TMO_CYC = (TMO_RAW < 1) ? 1 : TMO_RAW;
   localparam int     TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

   logic mode_p, inc_p, dec_p;

   button_conditioner #(.DEBOUNCE_CYC(DB_CYC), .HOLD_CYC(HD_CYC), .REPEAT_CYC(RP_CYC),
                        .REPEAT_EN(1'b0))
      u_btn_mode (.clk_i(clk), .rst_ni(reset), .btn_i(btn_mode), .press_o(mode_p));
   button_conditioner #(.DEBOUNCE_CYC(DB_CYC), .HOLD_CYC(HD_CYC), .REPEAT_CYC(RP_CYC),
                        .REPEAT_EN(1'b1))
      u_btn_inc (.clk_i(clk), .rst_ni(reset), .btn_i(btn_inc), .press_o(inc_p));
   button_conditioner #(.DEBOUNCE_CYC(DB_CYC), .HOLD_CYC(HD_CYC), .REPEAT_CYC(RP_CYC),
                        .REPEAT_EN(1'b1))
      u_btn_dec (.clk_i(clk), .rst_ni(reset), .btn_i(btn_dec), .press_o(dec_p));

   state_e           state_q, state_d;
   logic [HH_W-1:0]  hh_q, hh_d;
   logic [MS_W-1:0]  mm_q, mm_d, ss_q, ss_d;
   logic [SEC_W-1:0] load_q, load_d;
   logic             valid_q, valid_d;
   logic             active_q, active_d;
   logic [1:0]       field_q, field_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic [SEC_W-1:0] cs_clamped;
   logic [HH_W-1:0]  snap_hh;
   logic [MS_W-1:0]  snap_mm, snap_ss;
   logic             in_set, any_press;

   // Out-of-range core time is treated as midnight.
   assign cs_clamped = (cur_seconds >= SECONDS_PER_DAY) ? '0 : cur_seconds;
   assign snap_hh    = HH_W'(cs_clamped / SECONDS_PER_HOUR);
   assign snap_mm    = MS_W'((cs_clamped / SECONDS_PER_MIN) % SECONDS_PER_MIN);
   assign snap_ss    = MS_W'(cs_clamped % SECONDS_PER_MIN);
   assign any_press  = mode_p | inc_p | dec_p;
   assign in_set     = (state_q == ST_SET_HH) || (state_q == ST_SET_MM) ||
                       (state_q == ST_SET_SS);

   // Next state, field edits, idle timeout and registered output decode.
   always_comb begin
      state_d = state_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      load_d  = load_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (mode_p) begin
               hh_d    = snap_hh;
               mm_d    = snap_mm;
               ss_d    = snap_ss;
               tmo_d   = TMO_LOAD;
               state_d = ST_SET_HH;
            end
         end
         ST_SET_HH: begin
            hh_d = HH_W'(step_field(MS_W'(hh_q), 6'd23, inc_p, dec_p));
            if (mode_p) state_d = ST_SET_MM;
         end
         ST_SET_MM: begin
            mm_d = step_field(mm_q, 6'd59, inc_p, dec_p);
            if (mode_p) state_d = ST_SET_SS;
         end
         ST_SET_SS: begin
            ss_d = step_field(ss_q, 6'd59, inc_p, dec_p);
            if (mode_p) begin
               load_d  = to_seconds(hh_q, mm_q, ss_d);
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            if (load_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (in_set) begin
         if (any_press) begin
            tmo_d = TMO_LOAD;
         end else if (tmo_q == '0) begin
            state_d = ST_IDLE;
         end else begin
            tmo_d = tmo_q - 1'b1;
         end
      end
      valid_d  = (state_d == ST_COMMIT);
      active_d = (state_d != ST_IDLE);
      case (state_d)
         ST_SET_HH: field_d = FIELD_HH;
         ST_SET_MM: field_d = FIELD_MM;
         ST_SET_SS: field_d = FIELD_SS;
         default:   field_d = FIELD_NONE;
      endcase
   end

   // State and output registers; reset abandons any edit or pending load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         hh_q     <= '0;
         mm_q     <= '0;
         ss_q     <= '0;
         load_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
         field_q  <= FIELD_NONE;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         hh_q     <= hh_d;
         mm_q     <= mm_d;
         ss_q     <= ss_d;
         load_q   <= load_d;
         valid_q  <= valid_d;
         active_q <= active_d;
         field_q  <= field_d;
         tmo_q    <= tmo_d;
      end
   end

   assign load_valid   = valid_q;
   assign load_seconds = load_q;
   assign edit_active  = active_q;
   assign edit_field   = field_q;
   assign edit_hh      = hh_q;
   assign edit_mm      = mm_q;
   assign edit_ss      = ss_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with fast timing parameters:
// debounce 4, hold 10, repeat 5, timeout 1000 cycles.
module tb_clock_time_setter;

   logic        clk;
   logic        reset;
   logic        btn_mode, btn_inc, btn_dec;
   logic [16:0] cur_seconds;
   logic        load_ready;
   logic        load_valid;
   logic [16:0] load_seconds;
   logic        edit_active;
   logic [1:0]  edit_field;
   logic [4:0]  edit_hh;
   logic [5:0]  edit_mm, edit_ss;

   int n_checks = 0;
   int n_errors = 0;

   clock_time_setter #(
      .CLK_HZ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10), .REPEAT_MS(5), .TIMEOUT_S(1)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .cur_seconds(cur_seconds), .load_ready(load_ready),
      .load_valid(load_valid), .load_seconds(load_seconds),
      .edit_active(edit_active), .edit_field(edit_field),
      .edit_hh(edit_hh), .edit_mm(edit_mm), .edit_ss(edit_ss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Clean press of the buttons in m = {dec, inc, mode}: 8 cycles held
   // (short of the 10-cycle hold), then released long enough to settle.
   task automatic tap(input logic [2:0] m);
      @(negedge clk);
      {btn_dec, btn_inc, btn_mode} = m;
      repeat (8) @(negedge clk);
      {btn_dec, btn_inc, btn_mode} = 3'b000;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   logic [5:0] seen[$];
   logic [5:0] rep_exp [4];
   logic [5:0] prev;
   logic       saw_valid;

   initial begin
      rep_exp = '{6'd59, 6'd0, 6'd1, 6'd2};
      reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      cur_seconds = '0; load_ready = 1'b0;
      #1;
      check("rst_valid", load_valid, 0);
      check("rst_load", load_seconds, 0);
      check("rst_active", edit_active, 0);
      check("rst_field", edit_field, 0);
      check("rst_hh", edit_hh, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Snapshot 45296 = 12:34:56
      cur_seconds = 17'd45296;
      tap(3'b001);
      check("snap_field", edit_field, 1);
      check("snap_hh", edit_hh, 12);
      check("snap_mm", edit_mm, 34);
      check("snap_ss", edit_ss, 56);
      check("snap_active", edit_active, 1);
      check("snap_valid", load_valid, 0);

      // Wrap checks from 23:59:58
      do_reset();
      cur_seconds = 17'd86398;
      tap(3'b001);
      check("wrap_snap_hh", edit_hh, 23);
      tap(3'b010);
      check("hh_inc_wrap", edit_hh, 0);
      tap(3'b100);
      check("hh_dec_wrap", edit_hh, 23);
      tap(3'b110);
      check("hh_both", edit_hh, 23);
      tap(3'b001);
      check("mm_field", edit_field, 2);
      tap(3'b010);
      check("mm_inc_wrap", edit_mm, 0);
      tap(3'b100);
      check("mm_dec_wrap", edit_mm, 59);
      tap(3'b001);
      check("ss_field", edit_field, 3);
      check("ss_snap", edit_ss, 58);
      tap(3'b010);
      check("ss_inc", edit_ss, 59);

      // Commit 23:59:59 with core not ready
      tap(3'b001);
      for (int i = 0; i < 5; i++) begin
         check("commit_valid", load_valid, 1);
         check("commit_load", load_seconds, 86399);
         @(negedge clk);
      end
      check("commit_field", edit_field, 0);
      check("commit_active", edit_active, 1);
      tap(3'b010);
      check("commit_ign_ss", edit_ss, 59);
      check("commit_ign_valid", load_valid, 1);
      check("commit_ign_load", load_seconds, 86399);
      load_ready = 1'b1;
      @(negedge clk);
      load_ready = 1'b0;
      check("accept_valid", load_valid, 0);
      check("accept_field", edit_field, 0);
      check("accept_active", edit_active, 0);
      check("idle_keep_hh", edit_hh, 23);

      // Bounce on inc then a 4-cycle clean high: one increment only
      cur_seconds = 17'd86405;
      tap(3'b001);
      check("oor_snap_hh", edit_hh, 0);
      check("oor_snap_ss", edit_ss, 0);
      for (int i = 0; i < 5; i++) begin
         btn_inc = 1'b1;
         repeat (2) @(negedge clk);
         btn_inc = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("bounce_none", edit_hh, 0);
      btn_inc = 1'b1;
      repeat (4) @(negedge clk);
      btn_inc = 1'b0;
      repeat (12) @(negedge clk);
      check("bounce_one", edit_hh, 1);

      // Auto-repeat: held 23 cycles, release takes 6 more to propagate,
      // so pulses at +0, +10, +15, +20 after the first accepted press.
      tap(3'b001);
      tap(3'b001);
      tap(3'b100);
      tap(3'b100);
      check("rep_start", edit_ss, 58);
      @(negedge clk);
      btn_inc = 1'b1;
      prev = edit_ss;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 22) btn_inc = 1'b0;
         if (edit_ss != prev) begin
            seen.push_back(edit_ss);
            prev = edit_ss;
         end
      end
      check("rep_count", seen.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < seen.size()) check("rep_value", seen[i], rep_exp[i]);
         else check("rep_missing", 32'hFFFF_FFFF, rep_exp[i]);
      end

      // Timeout in SET_MM
      do_reset();
      cur_seconds = 17'd0;
      tap(3'b001);
      tap(3'b001);
      check("tmo_pre_field", edit_field, 2);
      saw_valid = 1'b0;
      repeat (900) begin
         @(negedge clk);
         if (load_valid) saw_valid = 1'b1;
      end
      check("tmo_not_yet", edit_field, 2);
      repeat (110) begin
         @(negedge clk);
         if (load_valid) saw_valid = 1'b1;
      end
      check("tmo_field", edit_field, 0);
      check("tmo_active", edit_active, 0);
      check("tmo_no_valid", saw_valid, 0);

      // Reset during COMMIT: 3723 = 01:02:03
      cur_seconds = 17'd3723;
      tap(3'b001);
      tap(3'b001);
      tap(3'b001);
      tap(3'b001);
      check("rc_valid", load_valid, 1);
      check("rc_load", load_seconds, 3723);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rc_async_valid", load_valid, 0);
      check("rc_async_active", edit_active, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("rc_after_valid", load_valid, 0);
      check("rc_after_field", edit_field, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
